// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default framing constants.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_rx_state_e;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 87;
  localparam int unsigned UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receiver: mid-bit sampling, framing-error detection.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial,
  output logic                 rx_dv,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 rx_active,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] CntMid  = CntW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_cfg
    $error("uart_rx_deframer: CLKS_PER_BIT must be at least 4");
  end

  logic                 rx_s;
  uart_rx_state_e       state;
  logic [CntW-1:0]      clk_cnt;
  logic [IdxW-1:0]      bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 armed;
  // rx_s carries the synchronizer reset value for two cycles; don't arm on it.
  logic [1:0]           sync_ok;
  logic                 parity_err;

  uart_sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_serial),
    .q     (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_idx      <= '0;
      shreg        <= '0;
      armed        <= 1'b0;
      sync_ok      <= 2'b00;
      rx_dv        <= 1'b0;
      rx_byte      <= '0;
      rx_active    <= 1'b0;
      rx_frame_err <= 1'b0;
      parity_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad   <= 1'b0;
`endif
    end else begin
      rx_dv        <= 1'b0;
      rx_frame_err <= 1'b0;
      parity_err   <= 1'b0;
      sync_ok      <= {sync_ok[0], 1'b1};
      case (state)
        IDLE: begin
          if (rx_s && sync_ok[1]) begin
            armed <= 1'b1;
          end
          if (armed && !rx_s) begin
            state     <= START;
            clk_cnt   <= '0;
            rx_active <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt == CntMid) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state     <= IDLE;
              rx_active <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CntW'(1);
          end
        end
        DATA: begin
          if (clk_cnt == CntLast) begin
            shreg[bit_idx] <= rx_s;
            clk_cnt        <= '0;
            if (bit_idx == IdxLast) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_idx <= bit_idx + IdxW'(1);
            end
          end else begin
            clk_cnt <= clk_cnt + CntW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt == CntLast) begin
            // Even parity: data bits plus parity bit carry an even number of ones.
            parity_bad <= rx_s ^ (^shreg);
            clk_cnt    <= '0;
            state      <= STOP;
          end else begin
            clk_cnt <= clk_cnt + CntW'(1);
          end
        end
`endif
        STOP: begin
          if (clk_cnt == CntLast) begin
            clk_cnt   <= '0;
            state     <= IDLE;
            rx_active <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= parity_bad;
`endif
            if (rx_s) begin
              rx_dv   <= 1'b1;
              rx_byte <= shreg;
            end else begin
              // Break or bad stop: wait for the line to return high before rearming.
              rx_frame_err <= 1'b1;
              armed        <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CntW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          clk_cnt   <= '0;
          rx_active <= 1'b0;
        end
      endcase
    end
  end

  assign rx_parity_err = parity_err;

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Serial-to-parallel UART receiver. It converts the asynchronous serial line into the `rx_dv`/`rx_byte` pair carried on the bench UART interface. It is the receive end of the 8N1 byte transmitter driven by `tx_dv`/`tx_byte`, and is used both in loopback and standalone. It samples each bit at mid-bit with a programmable clocks-per-bit divider, and reports framing errors.

Parameters:
- `CLKS_PER_BIT`, default 87, clk cycles per serial bit (10 MHz / 115200). Legal range ≥ 4; elaboration error otherwise.
- `DATA_BITS`, default 8, payload bits per frame, sent LSB first.

Ports:
- `clk` input 1: single clock, all logic on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rx_serial` input 1: asynchronous serial line, idles high.
- `rx_dv` output 1: one-cycle pulse, `rx_byte` valid.
- `rx_byte` output `DATA_BITS`: last good received byte.
- `rx_active` output 1: frame reception in progress.
- `rx_frame_err` output 1: one-cycle pulse, stop bit sampled low.
- `rx_parity_err` output 1: one-cycle pulse, parity mismatch (only meaningful with the optional feature).

Behaviour:
- Reset values: `rx_dv`=0, `rx_byte`=0, `rx_active`=0, `rx_frame_err`=0, `rx_parity_err`=0. Synchronizer flops reset to 1. State = IDLE, counters = 0, `armed`=0.
- `reset` asserts asynchronously mid-frame: abort immediately, no pulse emitted.
- `rx_serial` passes through a 2-flop synchronizer; `rx_s` is the synchronized value (2-cycle latency). All decisions use `rx_s`.
- `armed` is set when `rx_s`=1 is seen in IDLE. Start detection requires `armed`=1. After reset released mid-frame, the remainder of that frame is ignored until the line idles high.
- `clk_cnt` width is `$clog2(CLKS_PER_BIT)`; `bit_idx` width is `$clog2(DATA_BITS)`.
- States and transitions:
  - IDLE: if `armed` and `rx_s`=0, go to START with `clk_cnt`=0.
  - START: when `clk_cnt`==(`CLKS_PER_BIT`-1)/2, sample. If `rx_s`=0, go to DATA with `clk_cnt`=0, `bit_idx`=0. If `rx_s`=1, treat as a glitch and return to IDLE, no pulse. Otherwise `clk_cnt`++.
  - DATA: when `clk_cnt`==`CLKS_PER_BIT`-1, shift sample into shift register bit `bit_idx` and clear `clk_cnt`. When `bit_idx`==`DATA_BITS`-1, go to STOP (or PARITY with the optional feature); else `bit_idx`++. Otherwise `clk_cnt`++.
  - STOP: when `clk_cnt`==`CLKS_PER_BIT`-1, sample.
    - `rx_s`=1: next cycle `rx_dv`=1 and `rx_byte`=shift register. Go to IDLE.
    - `rx_s`=0: next cycle `rx_frame_err`=1, `rx_byte` unchanged, no `rx_dv`. Clear `armed`, go to IDLE. This covers a break condition: no new start is accepted until the line returns high.
- `rx_active`=1 in every state except IDLE, registered: rises the cycle after START entry and falls with the `rx_dv`/`rx_frame_err` pulse.
- Latency: `rx_dv` asserts 1 + 2 (sync) cycles after the mid-stop-bit instant of the raw line.
- `rx_byte` holds its value between frames.
- `rx_dv` and `rx_frame_err` are never high together.
- Back-to-back frames (start bit immediately after stop bit): no lost byte, because IDLE is re-entered mid-stop-bit, before the next falling edge.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- Defined:
  - A PARITY state follows DATA, with the same `CLKS_PER_BIT` timing, and samples an even-parity bit.
  - Parity mismatch: `rx_parity_err` pulses together with the frame's `rx_dv`, or with `rx_frame_err` if the stop bit also fails.
  - `rx_byte` is still updated on a parity error when the stop bit is good.
- Not defined:
  - No PARITY state; the frame is 8N1.
  - `rx_parity_err` is tied to 0.
  - The port list is identical in both builds.

Decomposition:
- Shared package `uart_pkg`:
  - State enum `uart_rx_state_e` {IDLE, START, DATA, PARITY, STOP}.
  - `UART_DEFAULT_CLKS_PER_BIT`=87.
  - `UART_DATA_BITS`=8.
- One sub-module, `uart_sync2`: 2-flop synchronizer with a reset-value parameter, set to 1 here. It is reused by future RX-side blocks.

Test Plan (`CLKS_PER_BIT`=16 for sim):
- Serial frame 0xA5 with a good stop bit: exactly one `rx_dv` pulse, `rx_byte`=0xA5, `rx_active` high for the whole frame, `rx_frame_err`=0.
- Frames 0x00, 0xFF, 0x3C sent back to back with no idle gap: three `rx_dv` pulses carrying those values in order, 160 cycles apart.
- Start-bit glitch, low for 5 cycles then high: stays IDLE after the check at the 8th cycle, no `rx_dv`, `rx_active` drops.
- 0x55 with the stop bit held low for 3 bit times, then high, then 0x81: one `rx_frame_err` pulse, no `rx_dv`, then `rx_dv` with 0x81.
- `reset` asserted mid data bit 4, released with the line still low mid-frame, then a full 0x6E frame: no output from the aborted frame, outputs zero after reset, then `rx_dv` with 0x6E.
- With `UART_RX_PARITY_EN`, frame 0x07 with the parity bit = 0 (wrong): `rx_dv` with 0x07 and `rx_parity_err` in the same cycle. Correct parity bit = 1: `rx_parity_err`=0.
